// File: rtl/branch_resolver.sv
// In-order tracker for control-flow predictions. Entries are queued at preRR and
// checked against the EX outcome, producing flush/redirect, predictor training bits and counters.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push1,
  input  logic             push2,
  input  logic             pred_taken1,
  input  logic             pred_taken2,
  input  logic [31:0]      pred_pc1,
  input  logic [31:0]      pred_pc2,
  input  logic             resolve1,
  input  logic             resolve2,
  input  logic             act_taken1,
  input  logic             act_taken2,
  input  logic [31:0]      act_next_pc1,
  input  logic [31:0]      act_next_pc2,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic             is_jump1,
  output logic             is_jump2,
  output logic             upd_valid1,
  output logic             upd_valid2,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] resolved_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic             err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: push/resolve are single-cycle strobes with no back-pressure; the
  // producer must respect full/empty, and violations are dropped and flagged on err.
  logic             ent_taken_q [DEPTH];
  logic [31:0]      ent_pc_q    [DEPTH];
  logic [AW-1:0]    head_q, tail_q, head_d, tail_d, idx2;
  logic [CW-1:0]    count_q, count_d, need2, free;
  logic             mispredict_q, is_jump1_q, is_jump2_q, upd_valid1_q, upd_valid2_q, err_q;
  logic [31:0]      redirect_q;
  logic [CNT_W-1:0] resolved_q, resolved_d, mispred_q, mispred_d;
  logic [CNT_W:0]   rsum, msum;
  logic             live, r1_ok, r2_ok, r2_match, mis1, mis2, mis, res_err, push_err;
  logic [1:0]       n_pop, n_req, n_acc;
  logic             d0_taken;
  logic [31:0]      d0_pc;

  always_comb begin
    live     = !mispredict_q;
    idx2     = resolve1 ? head_q + AW'(1) : head_q;
    need2    = resolve1 ? CW'(2) : CW'(1);
    r1_ok    = live && resolve1 && (count_q != '0);
    r2_match = live && resolve2 && (count_q >= need2);
    mis1     = r1_ok && (act_next_pc1 != ent_pc_q[head_q]);
    // An older mispredict squashes the younger slot entirely.
    r2_ok    = r2_match && !mis1;
    mis2     = r2_ok && (act_next_pc2 != ent_pc_q[idx2]);
    mis      = mis1 || mis2;
    res_err  = live && ((resolve1 && (count_q == '0)) || (resolve2 && (count_q < need2)));
    n_pop    = {1'b0, r1_ok} + {1'b0, r2_ok};

    free     = CW'(DEPTH) - count_q;
    n_req    = {1'b0, push1} + {1'b0, push2};
    push_err = live && !mis && (CW'(n_req) > free);
    n_acc    = 2'd0;
    if (live && !mis) n_acc = (CW'(n_req) > free) ? free[1:0] : n_req;
    d0_taken = push1 ? pred_taken1 : pred_taken2;
    d0_pc    = push1 ? pred_pc1 : pred_pc2;

    head_d   = head_q + AW'(n_pop);
    if (mis) begin
      tail_d  = head_d;
      count_d = '0;
    end else begin
      tail_d  = tail_q + AW'(n_acc);
      count_d = count_q - CW'(n_pop) + CW'(n_acc);
    end

    rsum       = {1'b0, resolved_q} + (CNT_W+1)'(n_pop);
    resolved_d = rsum[CNT_W] ? '1 : rsum[CNT_W-1:0];
    msum       = {1'b0, mispred_q} + (CNT_W+1)'(mis);
    mispred_d  = msum[CNT_W] ? '1 : msum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_taken_q[i] <= 1'b0;
        ent_pc_q[i]    <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      is_jump1_q   <= 1'b0;
      is_jump2_q   <= 1'b0;
      upd_valid1_q <= 1'b0;
      upd_valid2_q <= 1'b0;
      resolved_q   <= '0;
      mispred_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      if (n_acc != 2'd0) begin
        ent_taken_q[tail_q] <= d0_taken;
        ent_pc_q[tail_q]    <= d0_pc;
      end
      if (n_acc == 2'd2) begin
        ent_taken_q[tail_q + AW'(1)] <= pred_taken2;
        ent_pc_q[tail_q + AW'(1)]    <= pred_pc2;
      end
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      mispredict_q <= mis;
      if (mis) redirect_q <= mis1 ? act_next_pc1 : act_next_pc2;
      upd_valid1_q <= r1_ok;
      upd_valid2_q <= r2_ok;
      is_jump1_q   <= r1_ok && act_taken1;
      is_jump2_q   <= r2_ok && act_taken2;
      resolved_q   <= resolved_d;
      mispred_q    <= mispred_d;
      err_q        <= err_q || res_err || push_err;
    end
  end

  assign mispredict   = mispredict_q;
  assign redirect_pc  = redirect_q;
  assign is_jump1     = is_jump1_q;
  assign is_jump2     = is_jump2_q;
  assign upd_valid1   = upd_valid1_q;
  assign upd_valid2   = upd_valid2_q;
  assign full         = (count_q >= CW'(DEPTH - 1));
  assign empty        = (count_q == '0);
  assign resolved_cnt = resolved_q;
  assign mispred_cnt  = mispred_q;
  assign err          = err_q;
endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Counterpart to the branch predictor. Records every control-flow prediction issued at the preRR stage in an in-order tracking queue, then checks each one against the actual outcome computed in EX.
- Produces the pipeline flush/redirect, the per-slot actual-taken bits (`is_jump1`/`is_jump2`) that train the predictor, and performance counters.
- Two-wide; slot 1 is always older than slot 2.

Parameters:
- DEPTH, 4, tracking-queue entries (power of two, ≥2).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- push1  in  1  slot-1 control-flow instruction predicted at preRR.
- push2  in  1  slot-2 control-flow instruction predicted at preRR.
- pred_taken1  in  1  predictor's pre_branch, slot 1.
- pred_taken2  in  1  predictor's pre_branch, slot 2.
- pred_pc1  in  32  predictor's predict_pc, slot 1.
- pred_pc2  in  32  predictor's predict_pc, slot 2.
- resolve1  in  1  slot-1 control-flow instruction resolved in EX.
- resolve2  in  1  slot-2 control-flow instruction resolved in EX.
- act_taken1  in  1  actual branch/jump outcome, slot 1.
- act_taken2  in  1  actual branch/jump outcome, slot 2.
- act_next_pc1  in  32  correct next PC (target or pc+4), slot 1.
- act_next_pc2  in  32  correct next PC (target or pc+4), slot 2.
- mispredict  out  1  flush pulse.
- redirect_pc  out  32  fetch restart address, valid with mispredict.
- is_jump1  out  1  registered actual taken, slot 1, for predictor update.
- is_jump2  out  1  registered actual taken, slot 2, for predictor update.
- upd_valid1  out  1  is_jump1 is meaningful this cycle.
- upd_valid2  out  1  is_jump2 is meaningful this cycle.
- full  out  1  fewer than 2 free entries.
- empty  out  1  queue empty.
- resolved_cnt  out  CNT_W  resolved instructions.
- mispred_cnt  out  CNT_W  mispredictions.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst=0): queue empty, head=tail=0, count=0. mispredict=0, redirect_pc=0, is_jump*=0, upd_valid*=0, counters=0, err=0, full=0, empty=1. Reset mid-operation discards all entries immediately.
- Entry = {pred_taken, pred_pc}. Queue is a circular buffer; head/tail wrap modulo DEPTH.
- Push:
  - Enqueue in order: slot 1 then slot 2.
  - push2 without push1 enqueues the slot-2 data alone.
  - Space is checked against the registered count only; there is no same-cycle credit from pops.
  - A push exceeding the free space is dropped (for a double push with one free entry, slot 1 is kept) and sets err.
- Resolve:
  - resolve1 compares against the head entry; resolve2 compares against head+1 if resolve1 is also set, otherwise against the head.
  - Mispredict condition for an entry: act_next_pc ≠ stored pred_pc.
  - If slot 1 mispredicts, slot 2 is squashed: not popped, not counted, upd_valid2=0.
  - Resolve with no matching entry (empty, or only one entry for a double resolve) sets err; the unmatched slot is ignored.
- Outputs are registered; all effects appear 1 cycle after the resolve cycle:
  - upd_valid/is_jump per accepted resolve.
  - mispredict=1 for exactly one cycle, with redirect_pc = act_next_pc of the first mispredicting slot.
  - resolved_cnt advances by accepted resolves; mispred_cnt advances by 1 per mispredict.
- Flush:
  - On the edge that registers a mispredict, the whole queue is cleared (count=0, tail=head after pops); pushes in that cycle are dropped without err.
  - While mispredict=1, pushes and resolves are ignored (wrong-path) without err.
- Simultaneous push and pop in a non-flushing cycle: count_next = count − pops + accepted pushes.
- full = (count ≥ DEPTH−1). empty = (count == 0). Both are derived from the registered count.
- Counters saturate at all-ones.
- err clears only on reset.

Test Plan:
- Push1 {taken, 0x100}; next cycle resolve1 with act_taken=1, act_next_pc=0x100 → one cycle later is_jump1=1, upd_valid1=1, mispredict=0, resolved_cnt=1, empty=1.
- Push1 {not-taken, 0x204} and push2 {taken, 0x300} in the same cycle; then a double resolve with slot 1 act_next_pc=0x400 → mispredict=1 for one cycle, redirect_pc=0x400, upd_valid2=0, queue empty, mispred_cnt=1, resolved_cnt=1.
- JALR-style case: pred {taken, 0x80}, act_taken=1, act_next_pc=0x88 → mispredict=1, redirect_pc=0x88, is_jump1=1.
- DEPTH=4: fill 3 entries, then a double push → slot 1 accepted, slot 2 dropped, err=1, full=1. Then perform 4 single push/resolve pairs across the wrap → all match, err stays 1, no mispredict.
- resolve1 while empty → err=1, upd_valid1=0. Push 2 entries and assert rst mid-stream → all outputs return to reset values asynchronously, empty=1.
- Mispredict with a concurrent push1 in the resolve cycle → the push is dropped, count=0 after the edge, err unchanged.
